// File: rtl/dtree_sample_loader_if.sv
// ---------------------------------------------------------------------------
// dtree_sample_loader_if
// Bundles the two streams of the sample loader:
//   - byte input stream  : s_data/s_valid/s_last (to loader), s_ready (from loader)
//   - class result stream: m_class/m_err/m_valid (from loader), m_ready (to loader)
// Modports:
//   slave  - the loader side (consumes bytes, produces results)
//   master - the environment side (produces bytes, consumes results)
// ---------------------------------------------------------------------------
interface dtree_sample_loader_if #(
  parameter int FW = 8,
  parameter int CW = 3
);
  logic [FW-1:0] s_data;
  logic          s_valid;
  logic          s_last;
  logic          s_ready;
  logic [CW-1:0] m_class;
  logic          m_err;
  logic          m_valid;
  logic          m_ready;

  modport slave (
    input  s_data, s_valid, s_last, m_ready,
    output s_ready, m_class, m_err, m_valid
  );

  modport master (
    output s_data, s_valid, s_last, m_ready,
    input  s_ready, m_class, m_err, m_valid
  );
endinterface

// File: rtl/dtree_sample_loader.sv
// ---------------------------------------------------------------------------
// dtree_sample_loader
// Assembles one sample from a byte stream into the parallel feature vector of
// the combinational decision-tree classifier, holds it for SETTLE cycles,
// captures the class and returns it on a valid/ready result stream.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   io          - stream interface (slave modport): byte input, class output
//   feat_vec    - feature vector to the classifier, byte k at [FW*k +: FW]
//   cls_in      - classifier result (combinational in feat_vec)
//   busy        - high unless idle in LOAD with no byte of a sample received
//   sample_cnt  - results handed off (good and error), wraps at 16 bits
// ---------------------------------------------------------------------------
module dtree_sample_loader #(
  parameter int N_FEAT = 148,
  parameter int FW     = 8,
  parameter int CW     = 3,
  parameter int SETTLE = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  dtree_sample_loader_if.slave   io,
  output logic [N_FEAT*FW-1:0]   feat_vec,
  input  logic [CW-1:0]          cls_in,
  output logic                   busy,
  output logic [15:0]            sample_cnt
);

  localparam int              IW          = $clog2(N_FEAT);
  localparam logic [IW-1:0]   LAST_IDX    = IW'(N_FEAT - 1);
  localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_DISCARD = 2'd1,
    ST_SETTLE  = 2'd2,
    ST_RESULT  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [N_FEAT*FW-1:0]   feat_q, feat_d;
  logic [CW-1:0]          class_q, class_d;
  logic                   err_q, err_d;
  logic                   valid_q, valid_d;
  logic [15:0]            sample_cnt_q, sample_cnt_d;
  logic                   busy_q, busy_d;
  logic                   s_ready_q, s_ready_d;
  logic                   s_acc;

  // s_ready is registered but forced low while reset is asserted.
  assign io.s_ready = rst_n & s_ready_q;
  assign s_acc      = io.s_valid & io.s_ready;

  assign io.m_class = class_q;
  assign io.m_err   = err_q;
  assign io.m_valid = valid_q;
  assign feat_vec   = feat_q;
  assign busy       = busy_q;
  assign sample_cnt = sample_cnt_q;

  // Next-state and datapath update for the load/settle/result sequence.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    feat_d       = feat_q;
    class_d      = class_q;
    err_d        = err_q;
    valid_d      = valid_q;
    sample_cnt_d = sample_cnt_q;
    case (state_q)
      ST_LOAD: begin
        if (s_acc) begin
          feat_d[int'(idx_q)*FW +: FW] = io.s_data;
          if (io.s_last) begin
            idx_d = '0;
            if (idx_q == LAST_IDX) begin
              state_d = ST_SETTLE;
              cnt_d   = 4'd0;
            end else begin
              // Short frame: unwritten slots keep their previous contents.
              state_d = ST_RESULT;
              err_d   = 1'b1;
              class_d = '0;
              valid_d = 1'b1;
            end
          end else if (idx_q == LAST_IDX) begin
            // Long frame: idx parks at the last slot while the tail is dropped.
            state_d = ST_DISCARD;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_DISCARD: begin
        if (s_acc && io.s_last) begin
          state_d = ST_RESULT;
          idx_d   = '0;
          err_d   = 1'b1;
          class_d = '0;
          valid_d = 1'b1;
        end else begin
          state_d = ST_DISCARD;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_RESULT;
          class_d = cls_in;
          err_d   = 1'b0;
          valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_RESULT: begin
        if (valid_q && io.m_ready) begin
          state_d      = ST_LOAD;
          valid_d      = 1'b0;
          sample_cnt_d = sample_cnt_q + 16'd1;
        end else begin
          state_d = ST_RESULT;
        end
      end
      default: begin
        state_d = ST_LOAD;
        idx_d   = '0;
        valid_d = 1'b0;
      end
    endcase
    // Status outputs are registered from the next state to avoid glitches.
    busy_d    = !((state_d == ST_LOAD) && (idx_d == '0));
    s_ready_d = (state_d == ST_LOAD) || (state_d == ST_DISCARD);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_LOAD;
      idx_q        <= '0;
      cnt_q        <= 4'd0;
      feat_q       <= '0;
      class_q      <= '0;
      err_q        <= 1'b0;
      valid_q      <= 1'b0;
      sample_cnt_q <= 16'd0;
      busy_q       <= 1'b0;
      s_ready_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      feat_q       <= feat_d;
      class_q      <= class_d;
      err_q        <= err_d;
      valid_q      <= valid_d;
      sample_cnt_q <= sample_cnt_d;
      busy_q       <= busy_d;
      s_ready_q    <= s_ready_d;
    end
  end

endmodule

// File: tb/tb_dtree_sample_loader.sv
module tb_dtree_sample_loader;
  localparam int N_FEAT = 148;
  localparam int FW     = 8;
  localparam int CW     = 3;
  localparam int SETTLE = 2;

  logic                  clk;
  logic                  rst_n;
  logic [N_FEAT*FW-1:0]  feat_vec;
  logic [CW-1:0]         cls_in;
  logic                  busy;
  logic [15:0]           sample_cnt;

  dtree_sample_loader_if #(.FW(FW), .CW(CW)) io ();

  dtree_sample_loader #(.N_FEAT(N_FEAT), .FW(FW), .CW(CW), .SETTLE(SETTLE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .io         (io.slave),
    .feat_vec   (feat_vec),
    .cls_in     (cls_in),
    .busy       (busy),
    .sample_cnt (sample_cnt)
  );

  // Classifier stand-in: (slot0 + slot147) mod 8.
  assign cls_in = feat_vec[2:0] + feat_vec[(N_FEAT-1)*FW +: 3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [N_FEAT*FW-1:0] model_vec;
  logic [15:0]          exp_cnt;

  typedef struct {
    int         nbytes;
    int         base;
    int         step;
    logic       exp_err;
    logic [2:0] exp_cls;
    logic [7:0] exp_s147;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    int w;
    w = 0;
    @(negedge clk);
    io.s_data  = d;
    io.s_valid = 1'b1;
    io.s_last  = last;
    while (!io.s_ready && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (!io.s_ready) check("s_ready_timeout", 32'(io.s_ready), 32'd1);
    @(posedge clk);
  endtask

  task automatic send_frame(input int nbytes, input int base, input int step);
    logic [7:0] b;
    for (int k = 0; k < nbytes; k++) begin
      b = 8'(base + step * k);
      send_byte(b, k == nbytes - 1);
      if (k < N_FEAT) model_vec[k*FW +: FW] = b;
    end
  endtask

  // Wait for m_valid after the last byte edge; returns number of negedges seen.
  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      io.s_valid = 1'b0;
      io.s_last  = 1'b0;
      lat++;
    end while (!io.m_valid && lat < 50);
  endtask

  task automatic handshake(input string name);
    io.m_ready = 1'b1;
    @(posedge clk);
    #1;
    exp_cnt = exp_cnt + 16'd1;
    check({name, "_cnt"}, 32'(sample_cnt), 32'(exp_cnt));
    check({name, "_valid_drop"}, 32'(io.m_valid), 32'd0);
    check({name, "_sready_after"}, 32'(io.s_ready), 32'd1);
    io.m_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int bad;
    rst_n      = 1'b0;
    io.s_data  = 8'd0;
    io.s_valid = 1'b0;
    io.s_last  = 1'b0;
    io.m_ready = 1'b0;
    model_vec  = '0;
    exp_cnt    = 16'd0;

    vecs[0] = '{148, 0, 1, 1'b0, 3'd3, 8'd147};   // nominal 0..147
    vecs[1] = '{10,  9, 1, 1'b1, 3'd0, 8'd147};   // short frame, slot147 kept
    vecs[2] = '{148, 5, 1, 1'b0, 3'd5, 8'd152};   // 5+152=157 -> 5
    vecs[3] = '{150, 0, 1, 1'b1, 3'd0, 8'd147};   // long frame, tail dropped
    vecs[4] = '{148, 0, 3, 1'b0, 3'd1, 8'd185};   // 441&255=185 -> 1

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_feat_zero", 32'(feat_vec == '0), 32'd1);
    check("rst_m_valid", 32'(io.m_valid), 32'd0);
    check("rst_m_class", 32'(io.m_class), 32'd0);
    check("rst_m_err", 32'(io.m_err), 32'd0);
    check("rst_cnt", 32'(sample_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_s_ready_low", 32'(io.s_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_s_ready", 32'(io.s_ready), 32'd1);

    // Table-driven frames
    for (int i = 0; i < 5; i++) begin
      send_frame(vecs[i].nbytes, vecs[i].base, vecs[i].step);
      wait_result(lat);
      check($sformatf("v%0d_latency", i), 32'(lat),
            vecs[i].exp_err ? 32'd1 : 32'(SETTLE + 1));
      check($sformatf("v%0d_m_valid", i), 32'(io.m_valid), 32'd1);
      check($sformatf("v%0d_m_err", i), 32'(io.m_err), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_m_class", i), 32'(io.m_class), 32'(vecs[i].exp_cls));
      check($sformatf("v%0d_slot147", i), 32'(feat_vec[(N_FEAT-1)*FW +: FW]), 32'(vecs[i].exp_s147));
      check($sformatf("v%0d_feat_vec", i), 32'(feat_vec == model_vec), 32'd1);
      check($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
      handshake($sformatf("v%0d", i));
    end

    // Backpressure: result held while bytes are offered
    send_frame(148, 0, 1);
    wait_result(lat);
    io.s_valid = 1'b1;
    io.s_data  = 8'hAA;
    io.s_last  = 1'b0;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (io.m_valid !== 1'b1 || io.m_class !== 3'd3 || io.m_err !== 1'b0 ||
          io.s_ready !== 1'b0 || feat_vec !== model_vec) bad++;
      @(negedge clk);
    end
    check("bp_hold", 32'(bad), 32'd0);
    handshake("bp");
    io.s_valid = 1'b0;
    check("bp_feat_unchanged", 32'(feat_vec == model_vec), 32'd1);

    // Reset mid-load
    for (int k = 0; k < 60; k++) send_byte(8'hC0, 1'b0);
    @(negedge clk);
    io.s_valid = 1'b0;
    check("midload_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mr_feat_zero", 32'(feat_vec == '0), 32'd1);
    check("mr_m_valid", 32'(io.m_valid), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_s_ready", 32'(io.s_ready), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    model_vec = '0;
    exp_cnt   = 16'd0;
    send_frame(148, 0, 1);
    wait_result(lat);
    check("mr_m_class", 32'(io.m_class), 32'd3);
    check("mr_m_err", 32'(io.m_err), 32'd0);
    handshake("mr");
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (io.m_valid !== 1'b0) bad++;
    end
    check("mr_single_result", 32'(bad), 32'd0);

    // Counter wrap
    @(negedge clk);
    force dut.sample_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.sample_cnt_q;
    exp_cnt = 16'hFFFF;
    send_frame(1, 7, 1);
    wait_result(lat);
    check("wrap_m_err", 32'(io.m_err), 32'd1);
    handshake("wrap");
    check("wrap_zero", 32'(sample_cnt), 32'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dtree_sample_loader.md
Name: dtree_sample_loader

Overview:
Hardware-side front end for the combinational decision-tree classifier (148 8-bit features in, 3-bit class out). It receives one sample as a byte stream over a valid/ready interface and assembles the bytes into the parallel feature vector. It holds that vector stable to the classifier for a fixed settle time, captures the class, and returns it on an output valid/ready stream. It performs the same job as the file-driven bench, but in synthesizable RTL: features go in, class results come out, one sample at a time.

Parameters:
N_FEAT, 148, number of 8-bit features per sample; equals the classifier input count.
FW, 8, feature width in bits.
CW, 3, class width in bits.
SETTLE, 2, cycles the vector is held before cls_in is sampled; legal range 1..15.

Ports:
clk  in  1  single clock.
rst_n  in  1  synchronous, active-low reset.
s_data  in  FW  feature byte; the first byte is the lowest-indexed feature (X0), then ascending feature index.
s_valid  in  1  s_data valid.
s_last  in  1  marks the final byte of a sample; qualified by s_valid.
s_ready  out  1  loader accepts a byte this cycle.
feat_vec  out  N_FEAT*FW  to classifier; byte k drives bits [FW*k+FW-1 : FW*k].
cls_in  in  CW  classifier result (combinational function of feat_vec).
m_class  out  CW  captured class.
m_err  out  1  sample was framed incorrectly; m_class is 0 when set.
m_valid  out  1  result valid.
m_ready  in  1  downstream accepts the result.
busy  out  1  high in any state other than LOAD with index 0.
sample_cnt  out  16  number of results handed off (both good and error); wraps from 0xFFFF to 0.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=LOAD, byte index=0, feat_vec=0, m_valid=0, m_class=0, m_err=0, sample_cnt=0, busy=0.
  - s_ready=0 while rst_n=0.
  - Reset mid-operation discards any partial sample or pending result; no output is emitted.
- A byte is accepted when s_valid && s_ready at a clk edge. A result is taken when m_valid && m_ready.
- LOAD:
  - s_ready=1.
  - Each accepted byte is written to feat_vec slot[idx], then idx increments.
  - If s_last is set and idx==N_FEAT-1: go to SETTLE with settle count=0 and idx=0.
  - If s_last is set and idx<N_FEAT-1 (short frame): go to RESULT with m_err=1, m_class=0, idx=0. Slots not written keep their old values.
  - If the byte at idx==N_FEAT-1 is accepted without s_last (long frame): go to DISCARD.
- DISCARD:
  - s_ready=1; accepted bytes are dropped and feat_vec is unchanged.
  - On an accepted s_last: go to RESULT with m_err=1, m_class=0.
- SETTLE:
  - s_ready=0; feat_vec is held constant.
  - The counter increments each cycle.
  - On the cycle the counter equals SETTLE-1: capture m_class<=cls_in, set m_err<=0, go to RESULT.
- RESULT:
  - m_valid=1 and s_ready=0; m_class and m_err are held stable until the handshake.
  - On the handshake: m_valid<=0, sample_cnt increments, go to LOAD. s_ready=1 on the following cycle.
  - There is no bypass: the next sample's first byte is accepted no earlier than one cycle after the result handshake.
- Latency: if the last byte is accepted at edge t, m_valid is first high after edge t+SETTLE. With m_ready held high, the result handshake occurs at edge t+SETTLE+1.
- feat_vec changes only in LOAD. The classifier output is ignored outside the capture cycle.
- m_valid must never drop without a handshake, regardless of m_ready.
- The idx counter is $clog2(N_FEAT) bits. It never exceeds N_FEAT-1; DISCARD does not advance it.
- s_last without s_valid has no effect.

Test Plan:
1. Nominal:
   - Stimulus: 148 bytes with values 0..147 back-to-back, s_last on the final byte; model cls_in = feat_vec slot0 + slot147 (mod 8); m_ready=1.
   - Response: feat_vec slot k = k. At the handshake, m_class=3 and m_err=0. m_valid first high SETTLE (2) cycles after the last-byte edge, handshake at edge t+3. sample_cnt=1.
2. Backpressure:
   - Stimulus: as test 1 with m_ready=0 for 10 cycles after m_valid rises; s_valid is held at 1 with new bytes.
   - Response: m_valid stays 1 with m_class constant; s_ready=0 throughout; no byte is accepted; feat_vec is unchanged.
   - When m_ready=1: handshake, then s_ready=1 on the next cycle.
3. Short frame:
   - Stimulus: s_last on the 10th byte.
   - Response: immediate RESULT with m_err=1, m_class=0; sample_cnt increments after the handshake; the next 148-byte frame classifies correctly.
4. Long frame:
   - Stimulus: 150 bytes, s_last on byte 150.
   - Response: bytes 149 and 150 are dropped, feat_vec slot147 = byte 148, then m_err=1 and m_class=0 after s_last.
5. Reset mid-load:
   - Stimulus: rst_n=0 for 1 cycle after 60 bytes.
   - Response: feat_vec=0, m_valid=0, busy=0, s_ready=0 during reset. A subsequent full frame yields exactly one result, with sample_cnt=1 relative to reset.
6. Counter wrap:
   - Stimulus: force sample_cnt to 0xFFFF, then complete one sample.
   - Response: sample_cnt=0x0000.
